// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
// voice_alloc : polyphonic note-to-voice allocator with oldest-voice stealing
// Rev 1.0
// ============================================================================
module voice_alloc #(
    parameter int N_VOICES = 4,
    parameter int AGE_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_on,
    input  logic [6:0]                     cmd_note,
    input  logic [23:0]                    cmd_fcw,
    output logic [N_VOICES-1:0][23:0]      carrier_fcws,
    output logic [N_VOICES-1:0]            note_en,
    output logic                           stolen,
    output logic [$clog2(N_VOICES+1)-1:0]  active_count
);

    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int CNT_W = $clog2(N_VOICES + 1);

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;

    logic [1:0]                       state;
    logic                             cap_on;
    logic [6:0]                       cap_note;
    logic [23:0]                      cap_fcw;
    logic [N_VOICES-1:0][6:0]         note_q;
    logic [N_VOICES-1:0][AGE_W-1:0]   age_q;

    logic                             retrig_hit, free_hit, steal_nxt;
    logic [IDX_W-1:0]                 retrig_idx, free_idx, steal_idx, target;
    logic [AGE_W-1:0]                 best_age;
    logic [N_VOICES-1:0]              en_nxt;
    logic [N_VOICES-1:0][6:0]         note_nxt;
    logic [N_VOICES-1:0][23:0]        fcw_nxt;
    logic [N_VOICES-1:0][AGE_W-1:0]   age_nxt;
    logic [CNT_W-1:0]                 cnt_nxt;

    assign cmd_ready = (state == IDLE);

    // Candidate searches; loops run high-to-low so the lowest index wins.
    always_comb begin
        retrig_hit = 1'b0;
        retrig_idx = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        for (int i = N_VOICES - 1; i >= 0; i--) begin
            if (note_en[i] && note_q[i] == cap_note) begin
                retrig_hit = 1'b1;
                retrig_idx = IDX_W'(i);
            end
            if (!note_en[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        steal_idx = '0;
        best_age  = age_q[0];
        for (int i = 1; i < N_VOICES; i++) begin
            if (age_q[i] > best_age) begin
                best_age  = age_q[i];
                steal_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        en_nxt    = note_en;
        note_nxt  = note_q;
        fcw_nxt   = carrier_fcws;
        age_nxt   = age_q;
        steal_nxt = 1'b0;
        target    = '0;
        if (cap_on) begin
            target    = retrig_hit ? retrig_idx : (free_hit ? free_idx : steal_idx);
            steal_nxt = !retrig_hit && !free_hit;
            for (int i = 0; i < N_VOICES; i++) begin
                if (IDX_W'(i) == target) begin
                    en_nxt[i]   = 1'b1;
                    note_nxt[i] = cap_note;
                    fcw_nxt[i]  = cap_fcw;
                    age_nxt[i]  = '0;
                end else if (note_en[i] && age_q[i] != {AGE_W{1'b1}}) begin
                    age_nxt[i] = age_q[i] + 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (note_en[i] && note_q[i] == cap_note) begin
                    en_nxt[i]  = 1'b0;
                    age_nxt[i] = '0;
                end
            end
        end
        cnt_nxt = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(en_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            cap_on       <= 1'b0;
            cap_note     <= '0;
            cap_fcw      <= '0;
            note_en      <= '0;
            note_q       <= '0;
            carrier_fcws <= '0;
            age_q        <= '0;
            stolen       <= 1'b0;
            active_count <= '0;
        end else begin
            stolen <= 1'b0;
            case (state)
                INIT: state <= IDLE;
                IDLE: begin
                    if (cmd_valid) begin
                        cap_on   <= cmd_on;
                        cap_note <= cmd_note;
                        cap_fcw  <= cmd_fcw;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    note_en      <= en_nxt;
                    note_q       <= note_nxt;
                    carrier_fcws <= fcw_nxt;
                    age_q        <= age_nxt;
                    stolen       <= steal_nxt;
                    active_count <= cnt_nxt;
                    state        <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
`default_nettype wire
